// File: rtl/floo_err_pkg.sv
// Shared types for the error endpoint: channel encodings, response code,
// and the pending-transaction entry layouts kept in the internal FIFOs.
package floo_err_pkg;

  localparam int unsigned IdWidth    = 6;
  localparam int unsigned AxiIdWidth = 4;
  localparam int unsigned DataWidth  = 64;
  localparam int unsigned LenWidth   = 8;
  localparam int unsigned CntWidth   = 16;

  localparam logic [DataWidth-1:0] DefaultDataPattern = 64'hDEAD_BEEF_DEAD_BEEF;
  localparam logic [1:0]           RespSlvErr         = 2'b10;

  typedef enum logic [1:0] {
    ChAw   = 2'd0,
    ChW    = 2'd1,
    ChAr   = 2'd2,
    ChRsvd = 2'd3
  } req_ch_e;

  typedef enum logic {
    ChB = 1'b0,
    ChR = 1'b1
  } rsp_ch_e;

  typedef enum logic {
    RIdle  = 1'b0,
    RBurst = 1'b1
  } r_state_e;

  typedef struct packed {
    logic [IdWidth-1:0]    src;
    logic [AxiIdWidth-1:0] id;
  } aw_entry_t;

  typedef struct packed {
    logic [IdWidth-1:0]    src;
    logic [AxiIdWidth-1:0] id;
    logic [LenWidth-1:0]   len;
  } ar_entry_t;

  typedef struct packed {
    logic [IdWidth-1:0]    src;
    logic [AxiIdWidth-1:0] id;
  } b_entry_t;

endpackage

// File: rtl/floo_err_sync_fifo.sv
// Small synchronous FIFO with full/empty flags and a register-file head.
// Ports: push_i/data_i write side, pop_i/data_o read side, full_o/empty_o
// status. Push while full and pop while empty are ignored.
module floo_err_sync_fifo #(
  parameter int unsigned Depth = 4,
  parameter type         T     = logic
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic push_i,
  input  T     data_i,
  input  logic pop_i,
  output logic full_o,
  output logic empty_o,
  output T     data_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  T               mem_q [Depth];
  logic [PtrW-1:0] wptr_q, wptr_d;
  logic [PtrW-1:0] rptr_q, rptr_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            push_en, pop_en;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign full_o  = (cnt_q == CntW'(Depth));
  assign empty_o = (cnt_q == '0);
  assign data_o  = mem_q[rptr_q];
  assign push_en = push_i & ~full_o;
  assign pop_en  = pop_i & ~empty_o;

  // Pointer and occupancy update
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q + CntW'(push_en) - CntW'(pop_en);
    if (push_en) wptr_d = ptr_inc(wptr_q);
    if (pop_en)  rptr_d = ptr_inc(rptr_q);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // Storage needs no reset; occupancy gates every read
  always_ff @(posedge clk_i) begin
    if (push_en) mem_q[wptr_q] <= data_i;
  end

endmodule

// File: rtl/floo_err_endpoint.sv
// Error-responding endpoint for a router port with no real slave behind it.
// Absorbs AW/W/AR request flits and answers every write with one SLVERR B
// and every read with len+1 SLVERR R beats carrying DataPattern.
// Ports: req_* request flit in (req_ready_o is combinational),
// rsp_* response flit out (registered, AXI-style hold), err_count_o
// saturating count of completed error transactions.
module floo_err_endpoint
  import floo_err_pkg::*;
#(
  parameter int unsigned          AwDepth     = 4,
  parameter int unsigned          ArDepth     = 4,
  parameter int unsigned          BDepth      = 4,
  parameter logic [DataWidth-1:0] DataPattern = DefaultDataPattern
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [1:0]            req_ch_i,
  input  logic [IdWidth-1:0]    req_src_id_i,
  input  logic [AxiIdWidth-1:0] req_axi_id_i,
  input  logic [LenWidth-1:0]   req_len_i,
  input  logic                  req_last_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic                  rsp_ch_o,
  output logic [IdWidth-1:0]    rsp_dst_id_o,
  output logic [AxiIdWidth-1:0] rsp_axi_id_o,
  output logic [1:0]            rsp_resp_o,
  output logic [DataWidth-1:0]  rsp_data_o,
  output logic                  rsp_last_o,
  output logic [CntWidth-1:0]   err_count_o
);

  req_ch_e   req_ch;
  logic      req_fire, aw_push, aw_pop, ar_push, ar_pop, b_push, b_pop;
  logic      aw_full, aw_empty, ar_full, ar_empty, b_full, b_empty;
  aw_entry_t aw_head;
  ar_entry_t ar_head;
  b_entry_t  b_head;

  r_state_e              r_state_q, r_state_d;
  logic [IdWidth-1:0]    r_src_q, r_src_d;
  logic [AxiIdWidth-1:0] r_id_q, r_id_d;
  logic [LenWidth-1:0]   beat_cnt_q, beat_cnt_d;
  logic                  out_valid_q, out_valid_d;
  rsp_ch_e               out_ch_q, out_ch_d;
  logic [IdWidth-1:0]    out_dst_q, out_dst_d;
  logic [AxiIdWidth-1:0] out_id_q, out_id_d;
  logic                  out_last_q, out_last_d;
  rsp_ch_e               rr_q, rr_d;
  logic [CntWidth-1:0]   err_cnt_q, err_cnt_d;

  assign req_ch = req_ch_e'(req_ch_i);

  // Acceptance depends only on FIFO state and the presented channel
  always_comb begin
    req_ready_o = 1'b1;
    unique case (req_ch)
      ChAw:    req_ready_o = ~aw_full;
      ChW:     req_ready_o = ~aw_empty & (~req_last_i | ~b_full);
      ChAr:    req_ready_o = ~ar_full;
      default: req_ready_o = 1'b1;
    endcase
  end

  assign req_fire = req_valid_i & req_ready_o;
  assign aw_push  = req_fire & (req_ch == ChAw);
  assign ar_push  = req_fire & (req_ch == ChAr);
  // W-last retires the oldest AW into the B queue in the same cycle
  assign b_push   = req_fire & (req_ch == ChW) & req_last_i;
  assign aw_pop   = b_push;

  floo_err_sync_fifo #(.Depth(AwDepth), .T(aw_entry_t)) i_aw_fifo (
    .clk_i, .rst_i,
    .push_i  (aw_push),
    .data_i  ('{src: req_src_id_i, id: req_axi_id_i}),
    .pop_i   (aw_pop),
    .full_o  (aw_full),
    .empty_o (aw_empty),
    .data_o  (aw_head)
  );

  floo_err_sync_fifo #(.Depth(ArDepth), .T(ar_entry_t)) i_ar_fifo (
    .clk_i, .rst_i,
    .push_i  (ar_push),
    .data_i  ('{src: req_src_id_i, id: req_axi_id_i, len: req_len_i}),
    .pop_i   (ar_pop),
    .full_o  (ar_full),
    .empty_o (ar_empty),
    .data_o  (ar_head)
  );

  floo_err_sync_fifo #(.Depth(BDepth), .T(b_entry_t)) i_b_fifo (
    .clk_i, .rst_i,
    .push_i  (b_push),
    .data_i  ('{src: aw_head.src, id: aw_head.id}),
    .pop_i   (b_pop),
    .full_o  (b_full),
    .empty_o (b_empty),
    .data_o  (b_head)
  );

  // R burst sequencer, B/R round-robin and output register
  always_comb begin
    logic                  r_cand, b_cand, grant_b, grant_r, load_en, r_last;
    logic [IdWidth-1:0]    r_src;
    logic [AxiIdWidth-1:0] r_id;
    logic [LenWidth-1:0]   r_cnt;

    r_state_d   = r_state_q;
    r_src_d     = r_src_q;
    r_id_d      = r_id_q;
    beat_cnt_d  = beat_cnt_q;
    out_valid_d = out_valid_q;
    out_ch_d    = out_ch_q;
    out_dst_d   = out_dst_q;
    out_id_d    = out_id_q;
    out_last_d  = out_last_q;
    rr_d        = rr_q;
    err_cnt_d   = err_cnt_q;
    ar_pop      = 1'b0;
    b_pop       = 1'b0;

    // In IDLE the AR head is offered directly so the first beat costs no extra cycle
    r_cand = (r_state_q == RBurst) | ~ar_empty;
    r_src  = (r_state_q == RBurst) ? r_src_q    : ar_head.src;
    r_id   = (r_state_q == RBurst) ? r_id_q     : ar_head.id;
    r_cnt  = (r_state_q == RBurst) ? beat_cnt_q : ar_head.len;
    r_last = (r_cnt == '0);
    b_cand = ~b_empty;

    load_en = ~out_valid_q | rsp_ready_i;
    grant_b = load_en & b_cand & (~r_cand | (rr_q == ChB));
    grant_r = load_en & r_cand & ~grant_b;

    if (load_en) begin
      out_valid_d = grant_b | grant_r;
      if (grant_b) begin
        out_ch_d   = ChB;
        out_dst_d  = b_head.src;
        out_id_d   = b_head.id;
        out_last_d = 1'b1;
        b_pop      = 1'b1;
        rr_d       = ChR;
      end else if (grant_r) begin
        out_ch_d   = ChR;
        out_dst_d  = r_src;
        out_id_d   = r_id;
        out_last_d = r_last;
        rr_d       = ChB;
      end
    end

    // beat_cnt holds the number of beats still owed after the current one
    if (r_state_q == RIdle) begin
      if (~ar_empty) begin
        ar_pop  = 1'b1;
        r_src_d = ar_head.src;
        r_id_d  = ar_head.id;
        if (grant_r) begin
          if (!r_last) begin
            r_state_d  = RBurst;
            beat_cnt_d = ar_head.len - LenWidth'(1);
          end
        end else begin
          r_state_d  = RBurst;
          beat_cnt_d = ar_head.len;
        end
      end
    end else if (grant_r) begin
      if (r_last) r_state_d  = RIdle;
      else        beat_cnt_d = beat_cnt_q - LenWidth'(1);
    end

    if (out_valid_q && rsp_ready_i && (out_ch_q == ChB || out_last_q) && err_cnt_q != '1)
      err_cnt_d = err_cnt_q + CntWidth'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state_q   <= RIdle;
      r_src_q     <= '0;
      r_id_q      <= '0;
      beat_cnt_q  <= '0;
      out_valid_q <= 1'b0;
      out_ch_q    <= ChB;
      out_dst_q   <= '0;
      out_id_q    <= '0;
      out_last_q  <= 1'b0;
      rr_q        <= ChB;
      err_cnt_q   <= '0;
    end else begin
      r_state_q   <= r_state_d;
      r_src_q     <= r_src_d;
      r_id_q      <= r_id_d;
      beat_cnt_q  <= beat_cnt_d;
      out_valid_q <= out_valid_d;
      out_ch_q    <= out_ch_d;
      out_dst_q   <= out_dst_d;
      out_id_q    <= out_id_d;
      out_last_q  <= out_last_d;
      rr_q        <= rr_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign rsp_valid_o  = out_valid_q;
  assign rsp_ch_o     = out_ch_q;
  assign rsp_dst_id_o = out_dst_q;
  assign rsp_axi_id_o = out_id_q;
  assign rsp_last_o   = out_last_q;
  assign rsp_resp_o   = out_valid_q ? RespSlvErr : 2'b00;
  assign rsp_data_o   = (out_valid_q && out_ch_q == ChR) ? DataPattern : '0;
  assign err_count_o  = err_cnt_q;

endmodule
